// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I control pipeline.
// Opcodes, ALU/immediate classes and forwarding selects.
package rv_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int ALU_OP_W_DEF   = 2;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection: load-use stall, branch flush
// and EX operand forwarding selects.
module hazard_unit
    import rv_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_reg_write,
    input  logic                  ex_result_src,
    input  logic                  ex_branch,
    input  logic                  ex_zero,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  lu,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  pc_src,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b
);

    logic ex_is_load;
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    // result_src is high by decoder default, so reg_write must qualify it
    assign ex_is_load = ex_valid & ex_reg_write & ex_result_src;

    assign lu = ex_is_load & id_valid & (ex_rd != '0)
              & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    assign pc_src  = ex_valid & ex_branch & ex_zero;
    assign flush_d = pc_src;
    assign stall_f = lu & ~pc_src;
    assign stall_d = lu & ~pc_src;

    assign mem_fwd_ok = mem_valid & mem_reg_write & (mem_rd != '0);
    assign wb_fwd_ok  = wb_valid & wb_reg_write & (wb_rd != '0);

    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (mem_fwd_ok && mem_rd == ex_rs1)
            forward_a = FWD_MEM;
        else if (wb_fwd_ok && wb_rd == ex_rs1)
            forward_a = FWD_WB;
        if (mem_fwd_ok && mem_rd == ex_rs2)
            forward_b = FWD_MEM;
        else if (wb_fwd_ok && wb_rd == ex_rs2)
            forward_b = FWD_WB;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline registers for the RV32I core,
// with hazard controls from hazard_unit.
module ctrl_pipe
    import rv_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int ALU_OP_W   = ALU_OP_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_reg_write,
    input  logic                  id_alu_src,
    input  logic                  id_mem_write,
    input  logic                  id_result_src,
    input  logic                  id_branch,
    input  logic [1:0]            id_imm_src,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_zero,
    output logic                  ex_alu_src,
    output logic [1:0]            ex_imm_src,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic                  mem_mem_write,
    output logic                  wb_reg_write,
    output logic                  wb_result_src,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  pc_src
);

    logic                  ex_v, ex_rw, ex_as, ex_mw, ex_rs, ex_br;
    logic [1:0]            ex_imm;
    logic [ALU_OP_W-1:0]   ex_aop;
    logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;

    logic                  mem_v, mem_rw, mem_mw, mem_rs;
    logic [REG_ADDR_W-1:0] mem_rd;

    logic                  wb_v, wb_rw, wb_rs;
    logic [REG_ADDR_W-1:0] wb_rd_q;

    logic lu;
    logic bubble;

    assign bubble = lu | pc_src | ~id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v    <= 1'b0;
            ex_rw   <= 1'b0;
            ex_as   <= 1'b0;
            ex_mw   <= 1'b0;
            ex_rs   <= 1'b0;
            ex_br   <= 1'b0;
            ex_imm  <= '0;
            ex_aop  <= '0;
            ex_rs1  <= '0;
            ex_rs2  <= '0;
            ex_rd   <= '0;
            mem_v   <= 1'b0;
            mem_rw  <= 1'b0;
            mem_mw  <= 1'b0;
            mem_rs  <= 1'b0;
            mem_rd  <= '0;
            wb_v    <= 1'b0;
            wb_rw   <= 1'b0;
            wb_rs   <= 1'b0;
            wb_rd_q <= '0;
        end else begin
            if (bubble) begin
                ex_v   <= 1'b0;
                ex_rw  <= 1'b0;
                ex_as  <= 1'b0;
                ex_mw  <= 1'b0;
                ex_rs  <= 1'b0;
                ex_br  <= 1'b0;
                ex_imm <= '0;
                ex_aop <= '0;
                ex_rs1 <= '0;
                ex_rs2 <= '0;
                ex_rd  <= '0;
            end else begin
                ex_v   <= 1'b1;
                ex_rw  <= id_reg_write;
                ex_as  <= id_alu_src;
                ex_mw  <= id_mem_write;
                ex_rs  <= id_result_src;
                ex_br  <= id_branch;
                ex_imm <= id_imm_src;
                ex_aop <= id_alu_op;
                ex_rs1 <= id_rs1;
                ex_rs2 <= id_rs2;
                ex_rd  <= id_rd;
            end
            mem_v   <= ex_v;
            mem_rw  <= ex_rw;
            mem_mw  <= ex_mw;
            mem_rs  <= ex_rs;
            mem_rd  <= ex_rd;
            wb_v    <= mem_v;
            wb_rw   <= mem_rw;
            wb_rs   <= mem_rs;
            wb_rd_q <= mem_rd;
        end
    end

    assign ex_alu_src    = ex_v & ex_as;
    assign ex_imm_src    = ex_v ? ex_imm : '0;
    assign ex_alu_op     = ex_v ? ex_aop : '0;
    assign mem_mem_write = mem_v & mem_mw;
    assign wb_reg_write  = wb_v & wb_rw;
    assign wb_result_src = wb_v & wb_rs;
    assign wb_rd         = wb_v ? wb_rd_q : '0;

    hazard_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard (
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_valid      (ex_v),
        .ex_reg_write  (ex_rw),
        .ex_result_src (ex_rs),
        .ex_branch     (ex_br),
        .ex_zero       (ex_zero),
        .ex_rd         (ex_rd),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .mem_valid     (mem_v),
        .mem_reg_write (mem_rw),
        .mem_rd        (mem_rd),
        .wb_valid      (wb_v),
        .wb_reg_write  (wb_rw),
        .wb_rd         (wb_rd_q),
        .lu            (lu),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .pc_src        (pc_src),
        .forward_a     (forward_a),
        .forward_b     (forward_b)
    );

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed per-cycle vectors with
// hand-computed expected outputs, checked by a negedge monitor.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_reg_write, id_alu_src, id_mem_write;
    logic       id_result_src, id_branch;
    logic [1:0] id_imm_src, id_alu_op;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_zero;
    logic       ex_alu_src, mem_mem_write, wb_reg_write, wb_result_src;
    logic [1:0] ex_imm_src, ex_alu_op, forward_a, forward_b;
    logic [4:0] wb_rd;
    logic       stall_f, stall_d, flush_d, pc_src;

    typedef struct {
        string       nm;
        bit          chk;
        logic [20:0] v;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   passed = 0;
    logic [20:0] got;
    logic [20:0] zz;

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_reg_write  (id_reg_write),
        .id_alu_src    (id_alu_src),
        .id_mem_write  (id_mem_write),
        .id_result_src (id_result_src),
        .id_branch     (id_branch),
        .id_imm_src    (id_imm_src),
        .id_alu_op     (id_alu_op),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .ex_zero       (ex_zero),
        .ex_alu_src    (ex_alu_src),
        .ex_imm_src    (ex_imm_src),
        .ex_alu_op     (ex_alu_op),
        .mem_mem_write (mem_mem_write),
        .wb_reg_write  (wb_reg_write),
        .wb_result_src (wb_result_src),
        .wb_rd         (wb_rd),
        .forward_a     (forward_a),
        .forward_b     (forward_b),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .pc_src        (pc_src)
    );

    assign got = {ex_alu_src, ex_imm_src, ex_alu_op, mem_mem_write,
                  wb_reg_write, wb_result_src, wb_rd,
                  forward_a, forward_b, stall_f, stall_d, flush_d, pc_src};

    function automatic logic [20:0] mk(
        input logic as, input logic [1:0] imm, input logic [1:0] aop,
        input logic mw, input logic wrw, input logic wrs,
        input logic [4:0] wrd, input logic [1:0] fa, input logic [1:0] fb,
        input logic sf, input logic sd, input logic fd, input logic pc);
        return {as, imm, aop, mw, wrw, wrs, wrd, fa, fb, sf, sd, fd, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(
        input logic v, input logic rw, input logic as, input logic mw,
        input logic rs, input logic br, input logic [1:0] imm,
        input logic [1:0] aop, input logic [4:0] r1, input logic [4:0] r2,
        input logic [4:0] d);
        id_valid      = v;
        id_reg_write  = rw;
        id_alu_src    = as;
        id_mem_write  = mw;
        id_result_src = rs;
        id_branch     = br;
        id_imm_src    = imm;
        id_alu_op     = aop;
        id_rs1        = r1;
        id_rs2        = r2;
        id_rd         = d;
    endtask

    task automatic nop();
        id_set(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic expect_out(input string nm, input logic [20:0] v);
        ent_t e;
        e.nm  = nm;
        e.chk = 1'b1;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic skip();
        ent_t e;
        e.nm  = "skip";
        e.chk = 1'b0;
        e.v   = '0;
        sb.push_back(e);
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            ent_t e;
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if (got === e.v)
                    passed++;
                else
                    $display("FAIL %s: got %b expected %b", e.nm, got, e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        zz = '0;
        rst = 1'b1;
        ex_zero = 1'b1;
        id_set(1, 1, 1, 1, 1, 1, 2'b11, 2'b11, 5'd31, 5'd31, 5'd31);

        // cycle 1-2: reset with all-ones ID controls
        tick(); expect_out("reset", zz);
        tick();
        rst = 1'b0;
        ex_zero = 1'b0;
        id_set(1, 1, 0, 0, 0, 0, 2'b00, 2'b10, 5'd1, 5'd2, 5'd5);
        expect_out("reset_hold", zz);

        // R-type reaches WB three edges after ID
        tick(); nop();
        expect_out("rtype_ex", mk(0, 2'd0, 2'd2, 0, 0, 0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0));
        tick(); skip();
        tick();
        expect_out("rtype_wb", mk(0, 2'd0, 2'd0, 0, 1, 0, 5'd5, 2'd0, 2'd0, 0, 0, 0, 0));

        // load-use: load x3 then add using x3
        tick();
        id_set(1, 1, 1, 0, 1, 0, 2'b00, 2'b00, 5'd2, 5'd0, 5'd3);
        skip();
        tick();
        id_set(1, 1, 0, 0, 0, 0, 2'b00, 2'b10, 5'd3, 5'd4, 5'd6);
        expect_out("lu_stall", mk(1, 2'd0, 2'd0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 1, 1, 0, 0));
        tick();
        expect_out("lu_bubble", zz);
        tick(); nop();
        expect_out("lu_fwd_wb", mk(0, 2'd0, 2'd2, 0, 1, 1, 5'd3, 2'd1, 2'd0, 0, 0, 0, 0));
        tick(); skip();
        tick(); skip();

        // MEM beats WB when both write x7
        tick();
        id_set(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 5'd1, 5'd1, 5'd7);
        skip();
        tick();
        id_set(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 5'd1, 5'd1, 5'd7);
        skip();
        tick();
        id_set(1, 1, 0, 0, 0, 0, 2'b00, 2'b10, 5'd7, 5'd7, 5'd8);
        skip();
        tick(); nop();
        expect_out("fwd_prio", mk(0, 2'd0, 2'd2, 0, 1, 0, 5'd7, 2'd2, 2'd2, 0, 0, 0, 0));

        // writes to x0 never forward
        tick();
        id_set(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
        skip();
        tick();
        id_set(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
        skip();
        tick();
        id_set(1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 5'd0, 5'd0, 5'd9);
        skip();
        tick(); nop();
        expect_out("fwd_x0", mk(0, 2'd0, 2'd1, 0, 1, 0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0));

        // taken branch flushes a following store
        tick();
        id_set(1, 0, 0, 0, 0, 1, 2'b10, 2'b01, 5'd1, 5'd2, 5'd0);
        skip();
        tick();
        id_set(1, 0, 1, 1, 0, 0, 2'b01, 2'b00, 5'd1, 5'd2, 5'd0);
        ex_zero = 1'b1;
        expect_out("br_taken", mk(0, 2'd2, 2'd1, 0, 1, 0, 5'd9, 2'd0, 2'd0, 0, 0, 1, 1));
        tick(); nop();
        expect_out("br_flushed", zz);

        // not-taken branch
        tick();
        ex_zero = 1'b0;
        id_set(1, 0, 0, 0, 0, 1, 2'b10, 2'b01, 5'd1, 5'd2, 5'd0);
        skip();
        tick(); nop();
        expect_out("br_not_taken", mk(0, 2'd2, 2'd1, 0, 0, 0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0));

        // crafted branch that is also a load: branch wins over stall
        tick();
        id_set(1, 1, 0, 0, 1, 1, 2'b10, 2'b01, 5'd1, 5'd2, 5'd4);
        skip();
        tick();
        id_set(1, 1, 0, 0, 0, 0, 2'b00, 2'b10, 5'd4, 5'd5, 5'd6);
        ex_zero = 1'b1;
        expect_out("br_vs_lu", mk(0, 2'd2, 2'd1, 0, 0, 0, 5'd0, 2'd0, 2'd0, 0, 0, 1, 1));
        tick(); nop();
        expect_out("br_vs_lu_bubble", zz);

        // store in EX killed by reset
        tick();
        ex_zero = 1'b0;
        id_set(1, 0, 1, 1, 0, 0, 2'b01, 2'b00, 5'd1, 5'd2, 5'd0);
        skip();
        tick(); nop();
        rst = 1'b1;
        expect_out("store_ex", mk(1, 2'd1, 2'd0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0));
        tick();
        rst = 1'b0;
        expect_out("store_rst", zz);
        tick();
        expect_out("store_after", zz);

        // load to x0 never stalls
        tick();
        id_set(1, 1, 1, 0, 1, 0, 2'b00, 2'b00, 5'd1, 5'd0, 5'd0);
        skip();
        tick();
        id_set(1, 1, 0, 0, 0, 0, 2'b00, 2'b10, 5'd0, 5'd0, 5'd6);
        expect_out("lu_x0", mk(1, 2'd0, 2'd0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0));
        tick(); nop();
        expect_out("lu_x0_adv", mk(0, 2'd0, 2'd2, 0, 0, 0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0));

        // a store that completes reaches MEM write enable
        tick();
        id_set(1, 0, 1, 1, 0, 0, 2'b01, 2'b00, 5'd1, 5'd2, 5'd0);
        skip();
        tick(); nop();
        skip();
        tick();
        expect_out("store_mem", mk(0, 2'd0, 2'd0, 1, 0, 0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0));

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
